pixel_row_streamer: RTL and testbench

- Host-side driver for the lane-detect controller's pixel input interface (`start` / `rx_data` / `rx_valid` / `done_signal` / `tx_data` / `confidence`).
- Holds one 32-byte pixel row loaded by the host. On `go` it pulses the controller start, streams the row byte-by-byte, waits for done, and captures center/confidence.
- Presents the captured result on a valid/ready port, with a timeout if done never arrives.

---
 rtl/lane_npu_pkg.sv | 25 ++
 rtl/row_buffer.sv | 28 ++
 rtl/pixel_row_streamer.sv | 175 +++++++++++++++++
 tb/tb_pixel_row_streamer.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lane_npu_pkg.sv
// Shared types and constants for the lane-detect NPU host-side blocks.
// Pure declarations: no latency and no flow control.
// Defines the row geometry, the timeout marker, the streamer state enum and the result record.
package lane_npu_pkg;

    localparam int ROW_LEN = 32;
    localparam int DATA_W  = 8;

    localparam logic [DATA_W-1:0] TIMEOUT_CENTER = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_SEND,
        ST_WAIT_DONE,
        ST_RESULT
    } streamer_state_t;

    typedef struct packed {
        logic [DATA_W-1:0] center;
        logic [DATA_W-1:0] confidence;
        logic              timeout;
    } result_t;

endpackage

// File: rtl/row_buffer.sv
// One pixel row: ROW_LEN x DATA_W register file.
// Write lands on the next clk edge; read is combinational.
// No backpressure: out-of-range write addresses are discarded.
module row_buffer #(
    parameter int ROW_LEN = 32,
    parameter int DATA_W  = 8,
    localparam int AW     = $clog2(ROW_LEN)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [ROW_LEN];

    // Contents are deliberately not reset; the host reloads rows as needed.
    always_ff @(posedge clk) begin
        if (we && (32'(waddr) < 32'(ROW_LEN))) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pixel_row_streamer.sv
// Streams a host-loaded pixel row into the lane-detect controller and captures its result.
// go -> start pulse next cycle, bytes follow back-to-back; done -> res_valid one cycle later.
// Result held on res_valid until res_ready; go/loads ignored while busy. Pacing gaps: PIXEL_STREAM_PACE_EN.
module pixel_row_streamer #(
    parameter int ROW_LEN        = 32,
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int PACE_GAP       = 1,
    localparam int AW            = $clog2(ROW_LEN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_we,
    input  logic [AW-1:0]     load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic              go,
    output logic              busy,
    output logic              ctl_start,
    output logic [DATA_W-1:0] ctl_rx_data,
    output logic              ctl_rx_valid,
    input  logic              ctl_done,
    input  logic [DATA_W-1:0] ctl_center,
    input  logic [DATA_W-1:0] ctl_confidence,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_center,
    output logic [DATA_W-1:0] res_confidence,
    output logic              res_timeout
);

    import lane_npu_pkg::*;

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [AW-1:0]    LAST_IDX = AW'(ROW_LEN - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    streamer_state_t   state;
    logic [AW-1:0]     idx;
    logic [CNT_W-1:0]  wait_cnt;
    result_t           res_q;
    logic [AW-1:0]     rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              wr_en;

`ifdef PIXEL_STREAM_PACE_EN
    localparam int GAP_W = (PACE_GAP > 1) ? $clog2(PACE_GAP) : 1;
    logic [GAP_W-1:0] gap_cnt;
`else
    logic unused_pace;
    assign unused_pace = ^PACE_GAP;
`endif

    // Loads are blocked for the whole transfer so the row cannot change under the stream.
    assign wr_en   = load_we && !busy;
    // Look one byte ahead: the registered rx_data output is loaded with the next byte.
    assign rd_addr = (state == ST_SEND) ? idx + AW'(1) : '0;

    row_buffer #(
        .ROW_LEN (ROW_LEN),
        .DATA_W  (DATA_W)
    ) u_row_buffer (
        .clk   (clk),
        .we    (wr_en),
        .waddr (load_addr),
        .wdata (load_data),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            idx          <= '0;
            wait_cnt     <= '0;
            res_q        <= '0;
            busy         <= 1'b0;
            ctl_start    <= 1'b0;
            ctl_rx_data  <= '0;
            ctl_rx_valid <= 1'b0;
            res_valid    <= 1'b0;
`ifdef PIXEL_STREAM_PACE_EN
            gap_cnt      <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (go) begin
                        state     <= ST_START;
                        ctl_start <= 1'b1;
                        busy      <= 1'b1;
                        idx       <= '0;
                    end
                end

                // The controller enters receive one cycle after start, so byte 0 goes out next.
                ST_START: begin
                    ctl_start    <= 1'b0;
                    ctl_rx_valid <= 1'b1;
                    ctl_rx_data  <= rd_data;
                    idx          <= '0;
                    state        <= ST_SEND;
                end

                ST_SEND: begin
`ifdef PIXEL_STREAM_PACE_EN
                    if (!ctl_rx_valid) begin
                        if (gap_cnt == '0) begin
                            ctl_rx_valid <= 1'b1;
                            ctl_rx_data  <= rd_data;
                            idx          <= idx + AW'(1);
                        end else begin
                            gap_cnt <= gap_cnt - GAP_W'(1);
                        end
                    end else if (idx == LAST_IDX) begin
                        ctl_rx_valid <= 1'b0;
                        idx          <= '0;
                        wait_cnt     <= '0;
                        state        <= ST_WAIT_DONE;
                    end else if (PACE_GAP == 0) begin
                        ctl_rx_data <= rd_data;
                        idx         <= idx + AW'(1);
                    end else begin
                        ctl_rx_valid <= 1'b0;
                        gap_cnt      <= GAP_W'(PACE_GAP - 1);
                    end
`else
                    if (idx == LAST_IDX) begin
                        ctl_rx_valid <= 1'b0;
                        idx          <= '0;
                        wait_cnt     <= '0;
                        state        <= ST_WAIT_DONE;
                    end else begin
                        ctl_rx_data <= rd_data;
                        idx         <= idx + AW'(1);
                    end
`endif
                end

                // A done arriving on the expiry cycle still carries real data, so it wins.
                ST_WAIT_DONE: begin
                    if (ctl_done) begin
                        res_q     <= '{center: ctl_center, confidence: ctl_confidence, timeout: 1'b0};
                        res_valid <= 1'b1;
                        wait_cnt  <= '0;
                        state     <= ST_RESULT;
                    end else if (wait_cnt == TO_LAST) begin
                        res_q     <= '{center: TIMEOUT_CENTER, confidence: '0, timeout: 1'b1};
                        res_valid <= 1'b1;
                        wait_cnt  <= '0;
                        state     <= ST_RESULT;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end

                ST_RESULT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign res_center     = res_q.center;
    assign res_confidence = res_q.confidence;
    assign res_timeout    = res_q.timeout;

endmodule

// File: tb/tb_pixel_row_streamer.sv
// Scoreboard bench for pixel_row_streamer: the driver queues expected start pulses,
// bytes, results and status snapshots; a monitor pops and compares them as the DUT presents them.
module tb_pixel_row_streamer;

    localparam int PG = 2;
`ifdef PIXEL_STREAM_PACE_EN
    localparam int STEP = 1 + PG;
`else
    localparam int STEP = 1;
`endif
    localparam int LAST_C = 2 + 31 * STEP;

    logic       clk;
    logic       rst;
    logic       load_we;
    logic [4:0] load_addr;
    logic [7:0] load_data;
    logic       go;
    logic       busy;
    logic       ctl_start;
    logic [7:0] ctl_rx_data;
    logic       ctl_rx_valid;
    logic       ctl_done;
    logic [7:0] ctl_center;
    logic [7:0] ctl_confidence;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_center;
    logic [7:0] res_confidence;
    logic       res_timeout;

    pixel_row_streamer #(
        .ROW_LEN        (32),
        .DATA_W         (8),
        .TIMEOUT_CYCLES (16),
        .PACE_GAP       (PG)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .load_we        (load_we),
        .load_addr      (load_addr),
        .load_data      (load_data),
        .go             (go),
        .busy           (busy),
        .ctl_start      (ctl_start),
        .ctl_rx_data    (ctl_rx_data),
        .ctl_rx_valid   (ctl_rx_valid),
        .ctl_done       (ctl_done),
        .ctl_center     (ctl_center),
        .ctl_confidence (ctl_confidence),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .res_center     (res_center),
        .res_confidence (res_confidence),
        .res_timeout    (res_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        logic [7:0] d;
        int         at;
    } byte_exp_t;

    typedef struct {
        logic [7:0] c;
        logic [7:0] f;
        logic       t;
        int         at;
    } res_exp_t;

    typedef struct {
        int   at;
        logic busy;
        logic rxv;
        logic rv;
        logic st;
        logic res0;
    } st_exp_t;

    int        start_q[$];
    byte_exp_t byte_q[$];
    res_exp_t  res_q[$];
    st_exp_t   st_q[$];

    logic [7:0] row_m [32];

    int checks = 0;
    int errors = 0;
    bit finish_req = 0;
    bit fin_ack = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    // Monitor: all comparisons happen here, on the falling edge.
    initial begin : monitor
        res_exp_t cur;
        bit       res_act;
        res_act = 0;
        cur = '{c: 8'h0, f: 8'h0, t: 1'b0, at: 0};
        forever begin
            @(negedge clk);
            if (ctl_start) begin
                if (start_q.size() == 0) begin
                    chk("unexpected_start", 32'(edge_cnt), 32'hFFFF_FFFF);
                end else begin
                    chk("start_time", 32'(edge_cnt), 32'(start_q.pop_front()));
                end
            end
            if (ctl_rx_valid) begin
                if (byte_q.size() == 0) begin
                    chk("unexpected_byte", 32'(ctl_rx_data), 32'hFFFF_FFFF);
                end else begin
                    byte_exp_t b;
                    b = byte_q.pop_front();
                    chk("byte_data", 32'(ctl_rx_data), 32'(b.d));
                    chk("byte_time", 32'(edge_cnt), 32'(b.at));
                end
            end
            if (res_valid && !res_act) begin
                if (res_q.size() == 0) begin
                    chk("unexpected_result", 32'(edge_cnt), 32'hFFFF_FFFF);
                end else begin
                    cur = res_q.pop_front();
                    chk("res_center", 32'(res_center), 32'(cur.c));
                    chk("res_confidence", 32'(res_confidence), 32'(cur.f));
                    chk("res_timeout", 32'(res_timeout), 32'(cur.t));
                    chk("res_time", 32'(edge_cnt), 32'(cur.at));
                end
                res_act = 1;
            end else if (res_valid) begin
                chk("res_stable", {15'd0, res_center, res_confidence, res_timeout},
                    {15'd0, cur.c, cur.f, cur.t});
            end
            if (!res_valid) res_act = 0;
            while (st_q.size() > 0 && st_q[0].at <= edge_cnt) begin
                st_exp_t s;
                s = st_q.pop_front();
                chk("status_time", 32'(edge_cnt), 32'(s.at));
                chk("status_flags", {28'd0, busy, ctl_rx_valid, res_valid, ctl_start},
                    {28'd0, s.busy, s.rxv, s.rv, s.st});
                if (s.res0) chk("status_res_zero", {15'd0, res_center, res_confidence, res_timeout}, 32'd0);
            end
            if (finish_req && !fin_ack) begin
                chk("leftover_starts", 32'(start_q.size()), 32'd0);
                chk("leftover_bytes", 32'(byte_q.size()), 32'd0);
                chk("leftover_results", 32'(res_q.size()), 32'd0);
                chk("leftover_status", 32'(st_q.size()), 32'd0);
                fin_ack = 1;
            end
        end
    end

    task automatic push_st(input int at, input logic b, input logic rxv, input logic rv,
                           input logic st, input logic r0);
        st_q.push_back('{at: at, busy: b, rxv: rxv, rv: rv, st: st, res0: r0});
    endtask

    task automatic push_res(input int at, input logic [7:0] c, input logic [7:0] f, input logic t);
        res_q.push_back('{c: c, f: f, t: t, at: at});
    endtask

    // Issues go (optionally with a same-cycle write) and queues the expected stream.
    task automatic start_go(input bit wr, input logic [4:0] a, input logic [7:0] d,
                            input int nbytes, output int g);
        @(negedge clk);
        go = 1'b1;
        if (wr) begin
            load_we   = 1'b1;
            load_addr = a;
            load_data = d;
            row_m[a]  = d;
        end
        g = edge_cnt + 1;
        start_q.push_back(g);
        push_st(g + 1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < nbytes; k++) begin
            byte_q.push_back('{d: row_m[k], at: g + 1 + k * STEP});
        end
        @(negedge clk);
        go      = 1'b0;
        load_we = 1'b0;
    endtask

    task automatic wait_c(input int g, input int c);
        while (edge_cnt - g + 1 < c) @(negedge clk);
    endtask

    task automatic pulse_done(input logic [7:0] c, input logic [7:0] f);
        ctl_done       = 1'b1;
        ctl_center     = c;
        ctl_confidence = f;
        @(negedge clk);
        ctl_done       = 1'b0;
        ctl_center     = 8'h00;
        ctl_confidence = 8'h00;
    endtask

    initial begin : driver
        int g;
        rst = 1'b1;
        load_we = 1'b0;
        load_addr = '0;
        load_data = '0;
        go = 1'b0;
        ctl_done = 1'b0;
        ctl_center = '0;
        ctl_confidence = '0;
        res_ready = 1'b1;

        // Reset state, during and just after reset.
        repeat (2) @(negedge clk);
        push_st(edge_cnt + 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        push_st(edge_cnt + 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);

        for (int i = 0; i < 32; i++) begin
            load_we   = 1'b1;
            load_addr = 5'(i);
            load_data = 8'(i * 3);
            row_m[i]  = 8'(i * 3);
            @(negedge clk);
        end
        load_we = 1'b0;

        // Main transfer, dropped write during SEND, spurious done during SEND, held result.
        start_go(1'b0, 5'd0, 8'd0, 32, g);
        res_ready = 1'b0;
        wait_c(g, 6);
        load_we = 1'b1; load_addr = 5'd5; load_data = 8'hAA;
        @(negedge clk);
        load_we = 1'b0;
        wait_c(g, 10);
        pulse_done(8'd99, 8'd1);
        push_res(g + LAST_C + 7, 8'd14, 8'd200, 1'b0);
        wait_c(g, LAST_C + 7);
        pulse_done(8'd14, 8'd200);
        for (int i = 0; i < 10; i++) begin
            go = 1'b1;
            push_st(edge_cnt + 1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
            @(negedge clk);
        end
        go = 1'b0;
        res_ready = 1'b1;
        push_st(edge_cnt + 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        push_st(edge_cnt + 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);

        // Timeout, with a write-first load on the go cycle.
        start_go(1'b1, 5'd0, 8'h55, 32, g);
        push_st(g + LAST_C + 4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        push_res(g + LAST_C + 16, 8'hFF, 8'h00, 1'b1);
        wait_c(g, LAST_C + 20);

        // Done on the expiry cycle.
        start_go(1'b0, 5'd0, 8'd0, 32, g);
        push_res(g + LAST_C + 16, 8'd7, 8'd99, 1'b0);
        wait_c(g, LAST_C + 16);
        pulse_done(8'd7, 8'd99);
        wait_c(g, LAST_C + 20);

        // Reset while byte 10 is on the bus, then a clean restart.
        start_go(1'b0, 5'd0, 8'd0, 11, g);
        wait_c(g, 2 + 10 * STEP);
        rst = 1'b1;
        push_st(edge_cnt + 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        start_go(1'b0, 5'd0, 8'd0, 32, g);
        push_res(g + LAST_C + 7, 8'd3, 8'd4, 1'b0);
        wait_c(g, LAST_C + 7);
        pulse_done(8'd3, 8'd4);
        wait_c(g, LAST_C + 12);

        finish_req = 1;
        for (int i = 0; i < 10 && !fin_ack; i++) @(negedge clk);
        @(negedge clk);
        if (!fin_ack) begin
            errors++;
            $display("FAIL final_check: monitor did not acknowledge");
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
